// File: rtl/polyveck_invntt_seq_if.sv
// Handshake bundle for polyveck_invntt_seq: upstream vector transfer plus the
// request/response path to the external inverse-NTT core.
interface polyveck_invntt_seq_if #(
    parameter int unsigned K = 6
);
    localparam int unsigned PW = 8192;

    logic            rtr;
    logic [K*PW-1:0] linear_v_in;
    logic [K*PW-1:0] linear_v_out;
    logic            rts;
    logic            error;
    logic            core_rtr;
    logic [PW-1:0]   core_inp;
    logic [PW-1:0]   core_out;
    logic            core_rts;

    // Sequencer side
    modport slave (
        input  rtr, linear_v_in, core_out, core_rts,
        output linear_v_out, rts, error, core_rtr, core_inp
    );

    // Upstream producer / core side
    modport master (
        output rtr, linear_v_in, core_out, core_rts,
        input  linear_v_out, rts, error, core_rtr, core_inp
    );
endinterface

// File: rtl/polyveck_invntt_seq.sv
// Runs the external inverse-NTT core over each of the K polynomials in turn and
// optionally reduces every result coefficient into [0,Q).
module polyveck_invntt_seq #(
    parameter int unsigned K       = 6,
    parameter int unsigned Q       = 8380417,
    parameter int unsigned FREEZE  = 1,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    polyveck_invntt_seq_if.slave  bus
);
    localparam int unsigned PW    = 8192;
    localparam int unsigned CW    = 32;
    localparam int unsigned NC    = 256;
    localparam int unsigned VW    = K * PW;
    localparam int unsigned IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT);
    localparam logic signed [55:0] Q_S = 56'(Q);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_RTR  = 3'd1,
        S_LOAD      = 3'd2,
        S_WAIT_CORE = 3'd3,
        S_DONE      = 3'd4,
        S_ERR       = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               core_rtr_q, core_rtr_d;
    logic               rts_q, rts_d;
    logic               error_q, error_d;
    logic [PW-1:0]      core_inp_q, core_inp_d;
    logic [VW-1:0]      lvout_q, lvout_d;
    logic [PW-1:0]      vin_q  [K];
    logic [PW-1:0]      vin_d  [K];
    logic [PW-1:0]      vout_q [K];
    logic [PW-1:0]      vout_d [K];
    logic [PW-1:0]      frz_c;

    // Rounded quotient by 2^23 approximates a/Q closely enough that one
    // conditional add of Q lands every 32-bit input in [0,Q).
    function automatic logic [CW-1:0] f_coef(input logic [CW-1:0] a);
        logic signed [55:0] ae;
        logic signed [55:0] t;
        logic signed [55:0] r;
        ae = 56'($signed(a));
        t  = (ae + 56'sd4194304) >>> 23;
        r  = ae - t * Q_S;
        if (r < 56'sd0) r = r + Q_S;
        if (FREEZE != 0) return CW'(r);
        return a;
    endfunction

    always_comb begin
        for (int j = 0; j < NC; j++) begin
            frz_c[j*CW +: CW] = f_coef(bus.core_out[j*CW +: CW]);
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        core_rtr_d = core_rtr_q;
        core_inp_d = core_inp_q;
        rts_d      = rts_q;
        error_d    = error_q;
        lvout_d    = lvout_q;
        vin_d      = vin_q;
        vout_d     = vout_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_WAIT_RTR;
            end
            S_WAIT_RTR: begin
                if (bus.rtr) begin
                    for (int i = 0; i < K; i++) begin
                        vin_d[i] = bus.linear_v_in[i*PW +: PW];
                    end
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                core_inp_d = vin_q[idx_q];
                core_rtr_d = 1'b1;
                timer_d    = '0;
                state_d    = S_WAIT_CORE;
            end
            S_WAIT_CORE: begin
                core_rtr_d = 1'b1;
                timer_d    = timer_q + TMR_W'(1);
                if (bus.core_rts) begin
                    vout_d[idx_q] = frz_c;
                    core_rtr_d    = 1'b0;
                    if (idx_q == IDX_W'(K - 1)) begin
                        for (int i = 0; i < K; i++) begin
                            lvout_d[i*PW +: PW] = vout_d[i];
                        end
                        rts_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_LOAD;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    core_rtr_d = 1'b0;
                    error_d    = 1'b1;
                    state_d    = S_ERR;
                end
            end
            S_DONE: begin
                rts_d = 1'b1;
                if (!bus.rtr) begin
                    rts_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                error_d = 1'b1;
                rts_d   = 1'b0;
                if (!bus.rtr) begin
                    error_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                core_rtr_d = 1'b0;
                rts_d      = 1'b0;
                error_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            timer_q    <= '0;
            core_rtr_q <= 1'b0;
            core_inp_q <= '0;
            rts_q      <= 1'b0;
            error_q    <= 1'b0;
            lvout_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            core_rtr_q <= core_rtr_d;
            core_inp_q <= core_inp_d;
            rts_q      <= rts_d;
            error_q    <= error_d;
            lvout_q    <= lvout_d;
        end
    end

    // Working vectors carry no reset; every run rewrites them before use.
    always_ff @(posedge clock) begin
        vin_q  <= vin_d;
        vout_q <= vout_d;
    end

    assign bus.linear_v_out = lvout_q;
    assign bus.rts          = rts_q;
    assign bus.error        = error_q;
    assign bus.core_rtr     = core_rtr_q;
    assign bus.core_inp     = core_inp_q;
endmodule

// File: tb/tb_polyveck_invntt_seq.sv
// Self-checking bench: two sequencer instances (no freeze / freeze with short
// timeout) driven against a behavioural core and a modular-arithmetic model.
module tb_polyveck_invntt_seq;
    localparam int unsigned K0 = 6;
    localparam int unsigned K1 = 3;
    localparam int unsigned PW = 8192;
    localparam int unsigned NC = 256;
    localparam longint      QL = 64'd8380417;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    polyveck_invntt_seq_if #(.K(K0)) if0 ();
    polyveck_invntt_seq_if #(.K(K1)) if1 ();

    polyveck_invntt_seq #(.K(K0), .Q(8380417), .FREEZE(0), .TIMEOUT(64)) u_dut0 (
        .clock(clk), .reset(rst), .bus(if0.slave));
    polyveck_invntt_seq #(.K(K1), .Q(8380417), .FREEZE(1), .TIMEOUT(16)) u_dut1 (
        .clock(clk), .reset(rst), .bus(if1.slave));

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]      in0 [K0][NC];
    logic [31:0]      in1 [K1][NC];
    logic [K0*PW-1:0] exp0;
    logic [K1*PW-1:0] exp1;

    bit c0_inv = 0, c0_never = 0, c0_spur = 0;
    int c0_lat [K0];
    int c0_poly = 0, c0_cnt = 0;
    bit c1_never = 0;
    int c1_lat = 3, c1_cnt = 0;
    bit g_seen = 0;
    int g_run = 0;
    int gaps [$];

    // Core 0: answers after c0_lat[p] cycles, identity or bitwise inverse
    always @(negedge clk) begin
        if (if0.core_rtr === 1'b1) begin
            c0_cnt++;
            if (!c0_never && c0_poly < int'(K0) && c0_cnt == c0_lat[c0_poly] + 1) begin
                if0.core_rts = 1'b1;
                if0.core_out = c0_inv ? ~if0.core_inp : if0.core_inp;
                c0_poly++;
            end else begin
                if0.core_rts = 1'b0;
            end
        end else begin
            c0_cnt = 0;
            if (if0.rtr !== 1'b1) c0_poly = 0;
            if0.core_rts = c0_spur;
            if0.core_out = c0_spur ? '1 : '0;
        end
    end

    // Core 1: identity core with a single latency
    always @(negedge clk) begin
        if (if1.core_rtr === 1'b1) begin
            c1_cnt++;
            if0.linear_v_in = if0.linear_v_in;
            if (!c1_never && c1_cnt == c1_lat + 1) begin
                if1.core_rts = 1'b1;
                if1.core_out = if1.core_inp;
            end else begin
                if1.core_rts = 1'b0;
            end
        end else begin
            c1_cnt = 0;
            if1.core_rts = 1'b0;
            if1.core_out = '0;
        end
    end

    // Lengths of core_rtr low gaps between consecutive requests of dut0
    always @(negedge clk) begin
        if (if0.rtr !== 1'b1) begin
            g_seen = 0;
            g_run  = 0;
        end else if (if0.core_rtr === 1'b1) begin
            if (g_seen && g_run > 0) gaps.push_back(g_run);
            g_seen = 1;
            g_run  = 0;
        end else if (g_seen) begin
            g_run++;
        end
    end

    function automatic logic [31:0] mod_q(input logic [31:0] a);
        longint v;
        longint r;
        v = longint'($signed(a));
        r = v % QL;
        if (r < 0) r = r + QL;
        return 32'(r);
    endfunction

    function automatic int diff0();
        for (int j = 0; j < int'(K0 * NC); j++)
            if (if0.linear_v_out[j*32 +: 32] !== exp0[j*32 +: 32]) return j;
        return -1;
    endfunction

    function automatic int diff1();
        for (int j = 0; j < int'(K1 * NC); j++)
            if (if1.linear_v_out[j*32 +: 32] !== exp1[j*32 +: 32]) return j;
        return -1;
    endfunction

    task automatic load_in0(input bit rnd);
        for (int i = 0; i < int'(K0); i++)
            for (int j = 0; j < int'(NC); j++) begin
                in0[i][j] = rnd ? $urandom : 32'(1000 * i + j);
                if0.linear_v_in[(i*NC + j)*32 +: 32] = in0[i][j];
                exp0[(i*NC + j)*32 +: 32] = c0_inv ? ~in0[i][j] : in0[i][j];
            end
    endtask

    task automatic load_in1();
        for (int i = 0; i < int'(K1); i++)
            for (int j = 0; j < int'(NC); j++) begin
                in1[i][j] = $urandom;
                if (j < 8 && i == 1) in1[i][j] = 32'(QL) + 32'(j) - 32'd4;
                if1.linear_v_in[(i*NC + j)*32 +: 32] = in1[i][j];
                exp1[(i*NC + j)*32 +: 32] = mod_q(in1[i][j]);
            end
    endtask

    task automatic start0();
        repeat (2) @(negedge clk);
        if0.rtr = 1'b1;
    endtask

    task automatic start1();
        repeat (2) @(negedge clk);
        if1.rtr = 1'b1;
    endtask

    task automatic wait_rts0(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (if0.rts !== 1'b1 && cyc < budget);
    endtask

    task automatic wait_end1(input int budget);
        int cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (if1.rts !== 1'b1 && if1.error !== 1'b1 && cyc < budget);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if0.rtr = 1'b0;
        if1.rtr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({if0.rts, if0.error, if0.core_rtr} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags0 got=%b want=000", {if0.rts, if0.error, if0.core_rtr});
        end
        n_checks++;
        if (if0.core_inp !== '0) begin n_fail++; $display("FAIL reset_core_inp0 got nonzero want 0"); end
        n_checks++;
        if (if0.linear_v_out !== '0) begin n_fail++; $display("FAIL reset_vout0 got nonzero want 0"); end
        n_checks++;
        if ({if1.rts, if1.error, if1.core_rtr} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags1 got=%b want=000", {if1.rts, if1.error, if1.core_rtr});
        end
        n_checks++;
        if (if1.linear_v_out !== '0) begin n_fail++; $display("FAIL reset_vout1 got nonzero want 0"); end
    endtask

    // Identity core, fixed latency 5: exact rtr->rts latency and passthrough
    task automatic test_identity_latency();
        int cyc;
        c0_inv = 0; c0_spur = 0; c0_never = 0;
        for (int i = 0; i < int'(K0); i++) c0_lat[i] = 5;
        load_in0(1'b0);
        do_reset();
        if0.rtr = 1'b1;
        wait_rts0(200, cyc);
        n_checks++;
        if (if0.rts !== 1'b1) begin n_fail++; $display("FAIL t1_rts got=%b want=1 (timeout)", if0.rts); end
        n_checks++;
        if (cyc != 44) begin n_fail++; $display("FAIL t1_latency got=%0d want=44", cyc); end
        n_checks++;
        if (if0.linear_v_out !== exp0) begin
            n_fail++; $display("FAIL t1_data coef=%0d got=%h want=%h", diff0(),
                if0.linear_v_out[diff0()*32 +: 32], exp0[diff0()*32 +: 32]);
        end
        @(negedge clk); if0.rtr = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (if0.rts !== 1'b0) begin n_fail++; $display("FAIL t1_rts_fall got=%b want=0", if0.rts); end
    endtask

    // Input toggles every cycle after capture; rts held for 50 cycles in DONE
    task automatic test_capture_hold();
        int cyc = 0;
        c0_inv = 0;
        for (int i = 0; i < int'(K0); i++) c0_lat[i] = $urandom_range(1, 6);
        load_in0(1'b1);
        start0();
        repeat (2) @(posedge clk);
        while (if0.rts !== 1'b1 && cyc < 300) begin
            @(negedge clk); if0.linear_v_in = ~if0.linear_v_in;
            @(posedge clk); #1; cyc++;
        end
        n_checks++;
        if (if0.rts !== 1'b1) begin n_fail++; $display("FAIL t6_rts got=%b want=1 (timeout)", if0.rts); end
        for (int c = 0; c < 50; c++) begin
            @(negedge clk); if0.linear_v_in = ~if0.linear_v_in;
            @(posedge clk); #1;
            n_checks++;
            if (if0.rts !== 1'b1) begin n_fail++; $display("FAIL t6_rts_hold cyc=%0d got=%b want=1", c, if0.rts); end
        end
        n_checks++;
        if (if0.linear_v_out !== exp0) begin
            n_fail++; $display("FAIL t6_data coef=%0d got=%h want=%h", diff0(),
                if0.linear_v_out[diff0()*32 +: 32], exp0[diff0()*32 +: 32]);
        end
        @(negedge clk); if0.rtr = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (if0.rts !== 1'b0) begin n_fail++; $display("FAIL t6_rts_fall got=%b want=0", if0.rts); end
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if (if0.linear_v_out !== exp0) begin n_fail++; $display("FAIL t6_idle_hold coef=%0d", diff0()); end
    endtask

    // Per-poly latencies, inverting core, spurious core_rts while idle
    task automatic test_var_latency();
        int cyc;
        int lats [K0] = '{1, 9, 3, 20, 2, 7};
        c0_inv = 1;
        c0_spur = 1;
        for (int i = 0; i < int'(K0); i++) c0_lat[i] = lats[i];
        load_in0(1'b1);
        gaps.delete();
        start0();
        wait_rts0(400, cyc);
        n_checks++;
        if (if0.rts !== 1'b1) begin n_fail++; $display("FAIL t4_rts got=%b want=1 (timeout)", if0.rts); end
        n_checks++;
        if (if0.linear_v_out !== exp0) begin
            n_fail++; $display("FAIL t4_data coef=%0d got=%h want=%h", diff0(),
                if0.linear_v_out[diff0()*32 +: 32], exp0[diff0()*32 +: 32]);
        end
        n_checks++;
        if (gaps.size() != K0 - 1) begin n_fail++; $display("FAIL t4_gap_count got=%0d want=%0d", gaps.size(), K0 - 1); end
        foreach (gaps[g]) begin
            n_checks++;
            if (gaps[g] != 1) begin n_fail++; $display("FAIL t4_gap_len idx=%0d got=%0d want=1", g, gaps[g]); end
        end
        c0_spur = 0;
        @(negedge clk); if0.rtr = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (if0.rts !== 1'b0) begin n_fail++; $display("FAIL t4_rts_fall got=%b want=0", if0.rts); end
    endtask

    // Reset during poly 3 clears outputs; a fresh run leaves no stale data
    task automatic test_reset_mid();
        int cyc = 0;
        c0_inv = 0;
        for (int i = 0; i < int'(K0); i++) c0_lat[i] = 4;
        load_in0(1'b1);
        start0();
        do begin
            @(posedge clk); #1; cyc++;
        end while (!(c0_poly == 3 && if0.core_rtr === 1'b1) && cyc < 200);
        n_checks++;
        if (!(c0_poly == 3 && if0.core_rtr === 1'b1)) begin
            n_fail++; $display("FAIL t5_reach_poly3 got poly=%0d want=3", c0_poly);
        end
        @(negedge clk); rst = 1'b1; if0.rtr = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({if0.rts, if0.error, if0.core_rtr} !== 3'b000) begin
            n_fail++; $display("FAIL t5_flags got=%b want=000", {if0.rts, if0.error, if0.core_rtr});
        end
        n_checks++;
        if (if0.core_inp !== '0) begin n_fail++; $display("FAIL t5_core_inp got nonzero want 0"); end
        n_checks++;
        if (if0.linear_v_out !== '0) begin n_fail++; $display("FAIL t5_vout got nonzero want 0"); end
        @(negedge clk); rst = 1'b0;
        load_in0(1'b1);
        start0();
        wait_rts0(300, cyc);
        n_checks++;
        if (if0.rts !== 1'b1) begin n_fail++; $display("FAIL t5_rts got=%b want=1 (timeout)", if0.rts); end
        n_checks++;
        if (if0.linear_v_out !== exp0) begin
            n_fail++; $display("FAIL t5_data coef=%0d got=%h want=%h", diff0(),
                if0.linear_v_out[diff0()*32 +: 32], exp0[diff0()*32 +: 32]);
        end
        @(negedge clk); if0.rtr = 1'b0;
    endtask

    // Freeze of extreme and random coefficients
    task automatic test_freeze();
        logic [31:0] sp [5] = '{32'hFFFF_FFFF, 32'd8380417, 32'hFF80_1FFF, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] want [5] = '{32'd8380416, 32'd0, 32'd0, 32'd2096895, 32'd6283521};
        c1_never = 0;
        c1_lat = $urandom_range(1, 8);
        load_in1();
        for (int j = 0; j < 5; j++) begin
            in1[0][j] = sp[j];
            if1.linear_v_in[j*32 +: 32] = sp[j];
            exp1[j*32 +: 32] = mod_q(sp[j]);
        end
        start1();
        wait_end1(200);
        n_checks++;
        if (if1.rts !== 1'b1) begin n_fail++; $display("FAIL t2_rts got=%b want=1 (timeout)", if1.rts); end
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (if1.linear_v_out[j*32 +: 32] !== want[j]) begin
                n_fail++; $display("FAIL t2_special idx=%0d got=%0d want=%0d", j, if1.linear_v_out[j*32 +: 32], want[j]);
            end
        end
        n_checks++;
        if (if1.linear_v_out !== exp1) begin
            n_fail++; $display("FAIL t2_data coef=%0d got=%h want=%h", diff1(),
                if1.linear_v_out[diff1()*32 +: 32], exp1[diff1()*32 +: 32]);
        end
        @(negedge clk); if1.rtr = 1'b0;
    endtask

    // Silent core: error 16 cycles after request, cleared when rtr drops
    task automatic test_timeout();
        int cyc = 0;
        int n = 0;
        c1_never = 1;
        start1();
        do begin
            @(posedge clk); #1; cyc++;
        end while (if1.core_rtr !== 1'b1 && cyc < 50);
        n_checks++;
        if (if1.core_rtr !== 1'b1) begin n_fail++; $display("FAIL t3_req got=%b want=1 (timeout)", if1.core_rtr); end
        do begin
            @(posedge clk); #1; n++;
        end while (if1.error !== 1'b1 && n < 40);
        n_checks++;
        if (n != 16) begin n_fail++; $display("FAIL t3_err_delay got=%0d want=16", n); end
        n_checks++;
        if ({if1.error, if1.core_rtr, if1.rts} !== 3'b100) begin
            n_fail++; $display("FAIL t3_flags got=%b want=100", {if1.error, if1.core_rtr, if1.rts});
        end
        n_checks++;
        if (if1.linear_v_out !== exp1) begin n_fail++; $display("FAIL t3_vout_kept coef=%0d", diff1()); end
        repeat (5) @(posedge clk); #1;
        n_checks++;
        if (if1.error !== 1'b1) begin n_fail++; $display("FAIL t3_err_hold got=%b want=1", if1.error); end
        @(negedge clk); if1.rtr = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (if1.error !== 1'b0) begin n_fail++; $display("FAIL t3_err_clear got=%b want=0", if1.error); end
        c1_never = 0;
    endtask

    // Response on the last timer cycle wins; one cycle later times out
    task automatic test_timeout_boundary();
        c1_lat = 15;
        load_in1();
        start1();
        wait_end1(300);
        n_checks++;
        if ({if1.rts, if1.error} !== 2'b10) begin
            n_fail++; $display("FAIL tb_lat15_flags got=%b want=10", {if1.rts, if1.error});
        end
        n_checks++;
        if (if1.linear_v_out !== exp1) begin
            n_fail++; $display("FAIL tb_lat15_data coef=%0d got=%h want=%h", diff1(),
                if1.linear_v_out[diff1()*32 +: 32], exp1[diff1()*32 +: 32]);
        end
        @(negedge clk); if1.rtr = 1'b0;
        c1_lat = 16;
        start1();
        wait_end1(300);
        n_checks++;
        if ({if1.rts, if1.error} !== 2'b01) begin
            n_fail++; $display("FAIL tb_lat16_flags got=%b want=01", {if1.rts, if1.error});
        end
        @(negedge clk); if1.rtr = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (if1.error !== 1'b0) begin n_fail++; $display("FAIL tb_lat16_clear got=%b want=0", if1.error); end
    endtask

    initial begin
        if0.rtr = 1'b0; if0.linear_v_in = '0;
        if1.rtr = 1'b0; if1.linear_v_in = '0;
        test_reset();
        test_identity_latency();
        test_capture_hold();
        test_var_latency();
        test_reset_mid();
        test_freeze();
        test_timeout();
        test_timeout_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
